// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: multiply/divide op codes and sequencer states.
package mips_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath.
// Multiply: acc = {partial product, remaining multiplier bits}, shift-add to the right.
// Divide:   acc = {partial remainder, remaining dividend / quotient bits}, restoring
//           shift-subtract to the left.
module muldiv_step
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Both step variants are computed; is_div selects. The extra top bit of sum keeps the
    // carry of the add, the extra top bit of diff is the borrow of the trial subtract.
    always_comb begin
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                 (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        rem_sh = acc[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, operand};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   MD_IDLE | waiting; start launches an op, otherwise mthi/mtlo write HI/LO
//   MD_CALC | one radix-2 step per clock, WIDTH steps in total
//   MD_FIX  | sign correction / divide-by-zero override, write HI/LO, pulse done
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    md_state_e          state;
    logic [CNT_W-1:0]   counter;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   operand_q;
    logic [WIDTH-1:0]   rs_raw_q;
    logic               is_div_q;
    logic               div_zero_q;
    logic               neg_res_q;
    logic               neg_rem_q;

    logic               is_signed;
    logic               is_div;
    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   rs_abs;
    logic [WIDTH-1:0]   rt_abs;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    // Operand conditioning at launch: magnitudes for signed ops, raw values for unsigned.
    // The magnitude of the most negative value is itself read as unsigned, which is what
    // makes DIV 0x80000000 / -1 wrap to 0x80000000.
    always_comb begin
        is_signed = (op == MD_MULT) || (op == MD_DIV);
        is_div    = (op == MD_DIV) || (op == MD_DIVU);
        rs_neg    = is_signed & rs_val[WIDTH-1];
        rt_neg    = is_signed & rt_val[WIDTH-1];
        rs_abs    = rs_neg ? -rs_val : rs_val;
        rt_abs    = rt_neg ? -rt_val : rt_val;
    end

    // Sign correction applied to the finished accumulator.
    always_comb begin
        prod_fixed = neg_res_q ? -acc : acc;
        quo_fixed  = neg_res_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fixed  = neg_rem_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (operand_q),
        .is_div   (is_div_q),
        .acc_next (acc_next)
    );

    // Sequencer, iteration datapath and HI/LO registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= MD_IDLE;
            counter    <= '0;
            acc        <= '0;
            operand_q  <= '0;
            rs_raw_q   <= '0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        counter    <= '0;
                        rs_raw_q   <= rs_val;
                        is_div_q   <= is_div;
                        div_zero_q <= is_div && (rt_val == '0);
                        neg_res_q  <= rs_neg ^ rt_neg;
                        neg_rem_q  <= rs_neg;
                        operand_q  <= is_div ? rt_abs : rs_abs;
                        acc        <= {{WIDTH{1'b0}}, (is_div ? rs_abs : rt_abs)};
                        busy       <= 1'b1;
                        state      <= MD_CALC;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                MD_CALC: begin
                    acc     <= acc_next;
                    counter <= counter + 1'b1;
                    if (counter == CNT_W'(WIDTH-1)) begin
                        state <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    if (div_zero_q) begin
                        hi <= rs_raw_q;
                        lo <= '1;
                    end else if (is_div_q) begin
                        hi <= rem_fixed;
                        lo <= quo_fixed;
                    end else begin
                        hi <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo <= prod_fixed[WIDTH-1:0];
                    end
                    counter <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state   <= MD_IDLE;
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    muldiv_unit dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .wdata  (wdata),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    // MIPS semantics computed with 64-bit / native SV arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint          sa64, sb64, sp;
        longint unsigned ua64, ub64, up;
        int              sa, sb;
        h = '0;
        l = '0;
        case (o)
            2'd0: begin
                sa64 = $signed(a);
                sb64 = $signed(b);
                sp   = sa64 * sb64;
                h    = sp[63:32];
                l    = sp[31:0];
            end
            2'd1: begin
                ua64 = {32'h0, a};
                ub64 = {32'h0, b};
                up   = ua64 * ub64;
                h    = up[63:32];
                l    = up[31:0];
            end
            2'd2: begin
                if (b == 32'h0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    h = 32'h0;
                    l = 32'h8000_0000;
                end else begin
                    sa = $signed(a);
                    sb = $signed(b);
                    l  = sa / sb;
                    h  = sa % sb;
                end
            end
            default: begin
                if (b == 32'h0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endfunction

    // Launch one op and wait (bounded) for done. If skip_sync, start is raised in the
    // current cycle (used right at a done cycle for back-to-back issue).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit skip_sync,
                          output logic [31:0] h, output logic [31:0] l,
                          output int lat, output int bcnt);
        int n;
        bit got;
        if (!skip_sync) @(negedge clock);
        op = o;
        rs_val = a;
        rt_val = b;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        n = 0;
        bcnt = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clock);
            n++;
            if (busy) bcnt++;
            if (done) got = 1'b1;
        end
        lat = got ? n - 1 : -1;
        h = hi;
        l = lo;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL run_op_timeout: done not seen within %0d cycles (op=%0d)", n, o);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, want all zero", hi, lo, busy, done);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_vectors();
        logic [1:0]  v_op [8] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2};
        logic [31:0] v_a  [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                  32'd100, 32'h8000_0000, 32'd5, 32'hFFFF_FFF0};
        logic [31:0] v_b  [8] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                                  32'd7, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] v_hi [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF,
                                  32'd2, 32'h0, 32'd5, 32'hFFFF_FFF0};
        logic [31:0] v_lo [8] = '{32'hFFFF_FFEB, 32'h0000_0001, 32'h1, 32'hFFFF_FFFD,
                                  32'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] h, l;
        int lat, bcnt;
        for (int i = 0; i < 8; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], 1'b0, h, l, lat, bcnt);
            checks++;
            if (h !== v_hi[i] || l !== v_lo[i]) begin
                errors++;
                $display("FAIL vector%0d: hi=%h lo=%h, want hi=%h lo=%h", i, h, l, v_hi[i], v_lo[i]);
            end
            checks++;
            if (lat != 33 || bcnt != 33) begin
                errors++;
                $display("FAIL vector%0d_timing: latency=%0d busy_cycles=%0d, want 33/33", i, lat, bcnt);
            end
            @(negedge clock);
            checks++;
            if (done !== 1'b0 || hi !== v_hi[i] || lo !== v_lo[i]) begin
                errors++;
                $display("FAIL vector%0d_hold: done=%b hi=%h lo=%h after done cycle", i, done, hi, lo);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b, h, l, eh, el;
        int lat, bcnt;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1, 2:    b = 32'($urandom_range(1, 20));
                3:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            model(o, a, b, eh, el);
            run_op(o, a, b, 1'b0, h, l, lat, bcnt);
            checks++;
            if (h !== eh || l !== el || lat != 33) begin
                errors++;
                $display("FAIL random%0d op=%0d a=%h b=%h: hi=%h lo=%h lat=%0d, want hi=%h lo=%h lat=33",
                         i, o, a, b, h, l, lat, eh, el);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] h, l, eh, el;
        int lat, bcnt;
        run_op(2'd1, 32'd123456, 32'd789, 1'b0, h, l, lat, bcnt);
        model(2'd2, 32'hFFFF_FC00, 32'd37, eh, el);
        run_op(2'd2, 32'hFFFF_FC00, 32'd37, 1'b1, h, l, lat, bcnt);
        checks++;
        if (h !== eh || l !== el || lat != 33 || bcnt != 33) begin
            errors++;
            $display("FAIL back_to_back: hi=%h lo=%h lat=%0d busy=%0d, want hi=%h lo=%h 33/33",
                     h, l, lat, bcnt, eh, el);
        end
    endtask

    task automatic test_start_ignored_and_mt();
        logic [31:0] eh, el, prev_lo;
        int n;
        bit got;
        model(2'd1, 32'd1000, 32'd3000, eh, el);
        @(negedge clock);
        op = 2'd1; rs_val = 32'd1000; rt_val = 32'd3000; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (5) @(negedge clock);
        op = 2'd2; rs_val = 32'd77; rt_val = 32'd5; start = 1'b1;
        mthi = 1'b1; wdata = 32'h1234;
        @(negedge clock);
        start = 1'b0; mthi = 1'b0;
        n = 6; got = 1'b0;
        while (!got && n < 100) begin
            if (done) got = 1'b1;
            else begin
                @(negedge clock);
                n++;
            end
        end
        checks++;
        if (!got || n != 34 || hi !== eh || lo !== el) begin
            errors++;
            $display("FAIL start_while_busy: got=%b lat=%0d hi=%h lo=%h, want lat=33 hi=%h lo=%h",
                     got, n - 1, hi, lo, eh, el);
        end
        prev_lo = lo;
        @(negedge clock);
        mthi = 1'b1; wdata = 32'h1234;
        @(negedge clock);
        mthi = 1'b0;
        checks++;
        if (hi !== 32'h1234 || lo !== prev_lo) begin
            errors++;
            $display("FAIL mthi_idle: hi=%h lo=%h, want hi=00001234 lo=%h", hi, lo, prev_lo);
        end
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hABCD;
        @(negedge clock);
        mthi = 1'b0; mtlo = 1'b0;
        checks++;
        if (hi !== 32'hABCD || lo !== 32'hABCD) begin
            errors++;
            $display("FAIL mthi_mtlo_both: hi=%h lo=%h, want 0000abcd both", hi, lo);
        end
        op = 2'd1; rs_val = 32'd2; rt_val = 32'd3; start = 1'b1;
        mthi = 1'b1; wdata = 32'hFFFF;
        @(negedge clock);
        start = 1'b0; mthi = 1'b0;
        checks++;
        if (hi !== 32'hABCD || busy !== 1'b1) begin
            errors++;
            $display("FAIL mthi_vs_start: hi=%h busy=%b, want hi=0000abcd busy=1", hi, busy);
        end
        n = 1; got = 1'b0;
        while (!got && n < 100) begin
            if (done) got = 1'b1;
            else begin
                @(negedge clock);
                n++;
            end
        end
        checks++;
        if (!got || hi !== 32'h0 || lo !== 32'd6) begin
            errors++;
            $display("FAIL start_priority_result: got=%b hi=%h lo=%h, want hi=0 lo=6", got, hi, lo);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] h, l;
        int lat, bcnt;
        int dseen;
        @(negedge clock);
        op = 2'd0; rs_val = $urandom; rt_val = $urandom | 32'h1; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (10) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op: hi=%h lo=%h busy=%b done=%b, want all zero", hi, lo, busy, done);
        end
        @(negedge clock);
        reset = 1'b0;
        dseen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done || busy) dseen++;
        end
        checks++;
        if (dseen != 0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_abandons: busy/done cycles=%0d hi=%h lo=%h, want 0/0/0", dseen, hi, lo);
        end
        run_op(2'd1, 32'd6, 32'd7, 1'b0, h, l, lat, bcnt);
        checks++;
        if (h !== 32'h0 || l !== 32'd42 || lat != 33) begin
            errors++;
            $display("FAIL after_reset_multu: hi=%h lo=%h lat=%0d, want hi=0 lo=42 lat=33", h, l, lat);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_start_ignored_and_mt();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
